dc_ipu_iter_multiplier: RTL and testbench

- Iterative radix-2 shift-add unsigned multiplier for the IPU scaler datapath.
- It is the inverse operation of the array divider. It computes the scale products, and it rebuilds dividend = quotient*divisor + remainder to cross-check divider results.
- It processes one operand pair at a time over WIDTH cycles.
- It has a valid/ready handshake on both input and output.

---
 rtl/dc_ipu_iter_multiplier.sv | 150 +++++++++++++++
 tb/tb_dc_ipu_iter_multiplier.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_ipu_iter_multiplier.sv
// ---------------------------------------------------------------------------
// dc_ipu_iter_multiplier
//
// Iterative radix-2 shift-add unsigned multiplier for the IPU scaler datapath.
// It processes one operand pair at a time. Each pair spends exactly WIDTH
// cycles in RUN. Each RUN cycle inspects one multiplier bit and, when that
// bit is set, adds the shifted multiplicand into a 2*WIDTH-bit accumulator.
// It also rebuilds dividend = quotient*divisor + remainder when cross-checking
// results from the array divider.
//
// Optional feature (macro DC_IPU_MUL_ADD_EN):
//   When the macro is defined, port c exists and the accumulator starts from
//   zero-extended c, so p = a*b + c. When it is undefined, p = a*b. Timing and
//   handshake are the same in both builds.
//
// Ports:
//   clk        clock
//   nreset     asynchronous reset, active-low
//   in_valid   operand pair valid
//   in_ready   block can accept operands (high only in IDLE)
//   a          multiplicand, unsigned, WIDTH bits
//   b          multiplier, unsigned, WIDTH bits
//   c          addend, unsigned, WIDTH bits (only with DC_IPU_MUL_ADD_EN)
//   out_valid  product valid (high only in DONE)
//   out_ready  downstream accepts product
//   p          product, 2*WIDTH bits, registered
//   busy       high in RUN or DONE
//
// Parameters:
//   WIDTH      operand width, 2 or greater
// ---------------------------------------------------------------------------
module dc_ipu_iter_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
`ifdef DC_IPU_MUL_ADD_EN
  input  logic [WIDTH-1:0]     c,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_init;

  // Multiplicand weighted by the current bit position. The shift is done at
  // the full product width, so no high bits are lost.
  function automatic logic [2*WIDTH-1:0] shifted_mcand(
    input logic [WIDTH-1:0] mc,
    input logic [CNT_W-1:0] sh
  );
    shifted_mcand = {{WIDTH{1'b0}}, mc} << sh;
  endfunction

  // Accumulator start value. In the add build c is folded in at accept, so
  // RUN needs no extra cycle. The worst case (2^W-1)^2 + (2^W-1) still fits
  // in 2*WIDTH bits.
`ifdef DC_IPU_MUL_ADD_EN
  assign acc_init = {{WIDTH{1'b0}}, c};
`else
  assign acc_init = '0;
`endif

  // State register and datapath registers (asynchronous reset)
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)          state_d = S_RUN;
      S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
      S_DONE:  if (out_ready)         state_d = S_IDLE;
      default:                        state_d = S_IDLE;
    endcase
  end

  // Datapath next values. Operands are sampled only on the IDLE accept edge.
  // Input changes during RUN or DONE therefore do not affect the result.
  // RUN never ends early: all WIDTH bits are visited even when b is zero,
  // which keeps the latency fixed.
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          acc_d = acc_init;
          cnt_d = '0;
        end
      end
      S_RUN: begin
        if (b_q[cnt_q]) begin
          acc_d = acc_q + shifted_mcand(a_q, cnt_q);
        end
        cnt_d = cnt_q + 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output decode. p comes straight from the accumulator register. It is
  // stable through DONE and holds after the handshake until the next accept.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    p         = acc_q;
  end

endmodule

// File: tb/tb_dc_ipu_iter_multiplier.sv
// ---------------------------------------------------------------------------
// tb_dc_ipu_iter_multiplier
//
// Scoreboard bench for dc_ipu_iter_multiplier (WIDTH = 16).
// An input monitor pushes the arithmetic expectation (a*b, plus c in the
// DC_IPU_MUL_ADD_EN build) together with the accept cycle. An output monitor
// pops an entry when a new result appears. It compares the value and the
// latency, checks p stability under backpressure, checks the return to IDLE
// after each handshake, and checks the reset values.
// ---------------------------------------------------------------------------
module tb_dc_ipu_iter_multiplier;

  localparam int W = 16;

  logic           clk;
  logic           nreset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a, b, c;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*W-1:0] p;
  logic           busy;

  typedef struct {
    logic [2*W-1:0] prod;
    int             acc_cyc;
  } exp_t;

  exp_t           sb_q[$];
  int             cyc = 0;
  int             n_vec = 0;
  int             n_err = 0;
  int             rdy_mode = 0;
  logic           in_out = 1'b0;
  logic           hs_prev = 1'b0;
  logic [2*W-1:0] held_p = '0;

  dc_ipu_iter_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef DC_IPU_MUL_ADD_EN
    .c         (c),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream readiness: 0 = always ready, 1 = random stalls, 2 = stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Reference: plain arithmetic on the operands captured at accept
  function automatic logic [2*W-1:0] model(input logic [W-1:0] ma, mb, mc);
    logic [2*W-1:0] r;
    r = (2*W)'(ma) * (2*W)'(mb);
`ifdef DC_IPU_MUL_ADD_EN
    r = r + (2*W)'(mc);
`else
    r = r + (2*W)'(mc & '0);
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Input monitor: inputs are stable from the negedge to the next posedge, so
  // an accept seen here occurs on the following edge (cycle cyc+1).
  always @(negedge clk) begin
    if (nreset && in_valid && in_ready) begin
      sb_q.push_back('{model(a, b, c), cyc + 1});
    end
  end

  // Output monitor / checker
  always @(negedge clk) begin
    exp_t e;
    if (!nreset) begin
      sb_q.delete();
      in_out  = 1'b0;
      hs_prev = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_p",         64'(p),         64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_in_ready",  64'(in_ready),  64'd1);
    end else begin
      chk("busy_vs_in_ready", 64'(busy), 64'(!in_ready));
      if (hs_prev) begin
        chk("idle_after_hs_out_valid", 64'(out_valid), 64'd0);
        chk("idle_after_hs_in_ready",  64'(in_ready),  64'd1);
      end
      hs_prev = 1'b0;
      if (out_valid) begin
        chk("done_in_ready", 64'(in_ready), 64'd0);
        if (!in_out) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_result", 64'(sb_q.size()), 64'd1);
          end else begin
            e = sb_q.pop_front();
            chk("product", 64'(p), 64'(e.prod));
            chk("latency", 64'(cyc - e.acc_cyc), 64'(W));
          end
          held_p = p;
          in_out = 1'b1;
        end else begin
          chk("p_stable", 64'(p), 64'(held_p));
        end
        if (out_ready) begin
          in_out  = 1'b0;
          hs_prev = 1'b1;
        end
      end else if (in_out) begin
        chk("valid_dropped", 64'(out_valid), 64'(in_out));
        in_out = 1'b0;
      end
    end
  end

  task automatic issue(input logic [W-1:0] ta, tb, tc, input int junk);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    a = ta; b = tb; c = tc;
    @(negedge clk);
    while (!in_ready) begin
      guard++;
      if (guard > 200) begin
        $display("FAIL accept_timeout at cycle %0d: in_ready never rose", cyc);
        $fatal(1, "accept timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < junk; i++) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      @(posedge clk);
      #1;
    end
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (!(in_ready && !out_valid && sb_q.size() == 0)) begin
      guard++;
      if (guard > 1000) begin
        $display("FAIL idle_timeout at cycle %0d: outstanding=%0d", cyc, sb_q.size());
        $fatal(1, "idle timeout");
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int guard;
    nreset = 1'b0; in_valid = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (3) @(posedge clk);
    #1 nreset = 1'b1;

    // Directed values: 0x1234*0x10, all-ones, zero operands
    issue(16'h1234, 16'h0010, 16'h0000, 4);
    wait_idle();
    issue(16'hFFFF, 16'hFFFF, 16'h0000, 2);
    issue(16'hFFFF, 16'hFFFF, 16'hFFFF, 2);
    issue(16'hABCD, 16'h0000, 16'h0000, 0);
    issue(16'h0000, 16'hABCD, 16'h0000, 0);
    wait_idle();

    // Backpressure with in_valid held high and operands toggling
    rdy_mode = 2;
    issue(W'($urandom), W'($urandom), W'($urandom), 0);
    in_valid = 1'b1;
    guard = 0;
    do begin
      @(posedge clk);
      #1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      guard++;
    end while (!out_valid && guard < 100);
    if (!out_valid) begin
      $display("FAIL out_valid_timeout at cycle %0d: out_valid stayed low", cyc);
      $fatal(1, "result timeout");
    end
    repeat (5) begin
      @(posedge clk);
      #1;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
    end
    a = 16'h00FF; b = 16'h0101; c = 16'h0007;
    rdy_mode = 0;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_idle();

    // Reset in the middle of RUN, then a=3, b=5
    issue(W'($urandom), W'($urandom), W'($urandom), 0);
    repeat (7) @(posedge clk);
    #2 nreset = 1'b0;
    @(posedge clk);
    #1 nreset = 1'b1;
    issue(16'd3, 16'd5, 16'd0, 0);
    wait_idle();

    // Random traffic with random stalls and gaps
    rdy_mode = 1;
    for (int n = 0; n < 1000; n++) begin
      issue(W'($urandom), W'($urandom), W'($urandom), $urandom_range(0, 3));
    end
    rdy_mode = 0;
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
